// File: rtl/mp64_kem_dma.sv
// rtl/mp64_kem_dma.sv - bus-mastering byte mover between system memory and the mp64_kem buffer port
//
// Optional feature macro: MP64_KEM_DMA_IRQ_EN (adds irq_o, CTRL bit6 IE, CTRL bit7 irq clear).
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_i/addr_i/wdata_i/wen_i     CSR slave request (0x00 CTRL/STATUS, 0x08 MEM_ADDR, 0x10 LEN, 0x18 OFFSET)
//   rdata_o/ack_o                  CSR read data and acknowledge, one cycle after req_i
//   mem_*                          memory master port (64-bit words, 8-byte aligned)
//   kem_*                          KEM MMIO master port (BUF_SEL 0x08, DIN/DOUT 0x10, IDX_SET 0x18)
//   irq_o                          completion interrupt (only with MP64_KEM_DMA_IRQ_EN)

module mp64_kem_dma #(
    parameter int MAX_LEN = 2048,
    parameter int MEM_AW  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [5:0]        addr_i,
    input  logic [63:0]       wdata_i,
    input  logic              wen_i,
    output logic [63:0]       rdata_o,
    output logic              ack_o,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_be_o,
    output logic              mem_wen_o,
    input  logic [63:0]       mem_rdata_i,
    input  logic              mem_ack_i,
`ifdef MP64_KEM_DMA_IRQ_EN
    output logic              irq_o,
`endif
    output logic              kem_req_o,
    output logic [5:0]        kem_addr_o,
    output logic [63:0]       kem_wdata_o,
    output logic              kem_wen_o,
    input  logic [63:0]       kem_rdata_i,
    input  logic              kem_ack_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_SEL, S_IDX, S_FETCH, S_PUT, S_GET, S_STORE, S_DONE, S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        buf_q, buf_d, lane_q, lane_d, cap_lane_q, cap_lane_d;
    logic              dir_q, dir_d, abort_q, abort_d, gap_q, gap_d, cap_q, cap_d, ack_q;
    logic [7:0]        err_q, err_d, be_q, be_d;
    logic [11:0]       cnt_q, cnt_d, len_q, len_d;
    logic [10:0]       off_q, off_d;
    logic [63:0]       word_q, word_d, rdata_q, rdata_d;
    logic [MEM_AW-1:0] base_q, base_d, cur_q, cur_d;
`ifdef MP64_KEM_DMA_IRQ_EN
    logic              ie_q, ie_d, irq_q, irq_d;
`endif

    function automatic logic [11:0] buf_size(input logic [2:0] b);
        case (b)
            3'd0:    return 12'd64;
            3'd1:    return 12'd800;
            3'd2:    return 12'd1632;
            3'd3:    return 12'd768;
            default: return 12'd32;
        endcase
    endfunction

    logic        busy, ctrl_wr, start, mem_go, kem_go, mem_done, kem_done, last_byte;
    logic [11:0] cnt_inc;
    logic [12:0] span;
    logic [1:0]  st_code;

    assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign ctrl_wr   = req_i && wen_i && (addr_i == 6'h00);
    assign start     = ctrl_wr && wdata_i[0] && !busy;
    // gap_q forces one idle cycle on the port after every completed handshake
    assign mem_go    = (state_q inside {S_FETCH, S_STORE}) && !gap_q;
    assign kem_go    = (state_q inside {S_SEL, S_IDX, S_PUT, S_GET}) && !gap_q;
    assign mem_done  = mem_go && mem_ack_i;
    assign kem_done  = kem_go && kem_ack_i;
    assign cnt_inc   = cnt_q + 12'd1;
    assign last_byte = (cnt_inc == len_q);
    assign span      = {2'b00, off_q} + {1'b0, len_q};
    assign st_code   = (state_q == S_IDLE) ? 2'd0 : (state_q == S_DONE) ? 2'd2 :
                       (state_q == S_ERR) ? 2'd3 : 2'd1;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        dir_d      = dir_q;
        abort_d    = abort_q;
        gap_d      = 1'b0;
        cap_d      = 1'b0;
        cap_lane_d = cap_lane_q;
        lane_d     = lane_q;
        err_d      = err_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        off_d      = off_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        base_d     = base_q;
        cur_d      = cur_q;

        if (req_i) begin
            case (addr_i)
                6'h00:   rdata_d = {32'd0, 4'd0, cnt_q, err_q, 6'd0, st_code};
                6'h08:   rdata_d = 64'(base_q);
                6'h10:   rdata_d = {52'd0, len_q};
                6'h18:   rdata_d = {53'd0, off_q};
                default: rdata_d = 64'd0;
            endcase
        end
        if (req_i && wen_i && !busy) begin
            case (addr_i)
                6'h08:   base_d = {wdata_i[MEM_AW-1:3], 3'b000};
                6'h10:   len_d  = wdata_i[11:0];
                6'h18:   off_d  = wdata_i[10:0];
                default: ;
            endcase
        end
        if (ctrl_wr && wdata_i[5] && busy) abort_d = 1'b1;

        // KEM read data arrives the cycle after its ack; pack it into the lane saved at ack time
        if (cap_q) begin
            word_d[{cap_lane_q, 3'b000} +: 8] = kem_rdata_i[7:0];
            be_d[cap_lane_q]                  = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) begin
                state_d = S_CHECK;
                buf_d   = wdata_i[4:2];
                dir_d   = wdata_i[1];
                cnt_d   = 12'd0;
                err_d   = 8'd0;
                lane_d  = 3'd0;
                cur_d   = base_q;
                word_d  = 64'd0;
                be_d    = 8'd0;
            end
            S_CHECK: begin
                if (abort_q)                          state_d = S_IDLE;
                else if (buf_q > 3'd4)                begin state_d = S_ERR; err_d = 8'd1; end
                else if (len_q == 12'd0)              begin state_d = S_ERR; err_d = 8'd3; end
                else if (span > {1'b0, buf_size(buf_q)} || {1'b0, len_q} > 13'(MAX_LEN))
                                                      begin state_d = S_ERR; err_d = 8'd2; end
                else                                  state_d = S_SEL;
            end
            S_SEL: if (kem_done) begin
                gap_d   = 1'b1;
                state_d = abort_q ? S_IDLE : S_IDX;
            end
            S_IDX: if (kem_done) begin
                gap_d   = 1'b1;
                state_d = abort_q ? S_IDLE : (dir_q ? S_GET : S_FETCH);
            end
            S_FETCH: if (mem_done) begin
                gap_d   = 1'b1;
                word_d  = mem_rdata_i;
                state_d = abort_q ? S_IDLE : S_PUT;
            end
            S_PUT: if (kem_done) begin
                gap_d = 1'b1;
                if (abort_q) state_d = S_IDLE;
                else begin
                    cnt_d  = cnt_inc;
                    lane_d = lane_q + 3'd1;
                    if (lane_q == 3'd7 || last_byte) cur_d = cur_q + MEM_AW'(8);
                    state_d = last_byte ? S_DONE : ((lane_q == 3'd7) ? S_FETCH : S_PUT);
                end
            end
            S_GET: if (kem_done) begin
                gap_d = 1'b1;
                if (abort_q) state_d = S_IDLE;
                else begin
                    cnt_d      = cnt_inc;
                    cap_d      = 1'b1;
                    cap_lane_d = lane_q;
                    lane_d     = lane_q + 3'd1;
                    state_d    = (lane_q == 3'd7 || last_byte) ? S_STORE : S_GET;
                end
            end
            S_STORE: if (mem_done) begin
                gap_d = 1'b1;
                if (abort_q) state_d = S_IDLE;
                else begin
                    cur_d   = cur_q + MEM_AW'(8);
                    word_d  = 64'd0;
                    be_d    = 8'd0;
                    lane_d  = 3'd0;
                    state_d = (cnt_q == len_q) ? S_DONE : S_GET;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort seen while the port is idle between handshakes: nothing outstanding, stop now
        if (busy && gap_q && abort_q) state_d = S_IDLE;
        if (state_d inside {S_IDLE, S_DONE, S_ERR}) abort_d = 1'b0;
    end

`ifdef MP64_KEM_DMA_IRQ_EN
    always_comb begin
        ie_d  = ie_q;
        irq_d = irq_q;
        if (ctrl_wr) begin
            ie_d = wdata_i[6];
            if (wdata_i[7]) irq_d = 1'b0;
        end
        if (start) irq_d = 1'b0;
        if (ie_q && (state_d inside {S_DONE, S_ERR}) && (state_d != state_q)) irq_d = 1'b1;
    end
    assign irq_o = irq_q;
`endif

    always_comb begin
        mem_req_o   = mem_go;
        mem_addr_o  = '0;
        mem_wdata_o = 64'd0;
        mem_be_o    = 8'd0;
        mem_wen_o   = 1'b0;
        kem_req_o   = kem_go;
        kem_addr_o  = 6'd0;
        kem_wdata_o = 64'd0;
        kem_wen_o   = 1'b0;
        if (mem_go) begin
            mem_addr_o = cur_q;
            mem_be_o   = 8'hFF;
            if (state_q == S_STORE) begin
                mem_wdata_o = word_q;
                mem_be_o    = be_q;
                mem_wen_o   = 1'b1;
            end
        end
        if (kem_go) begin
            case (state_q)
                S_SEL:   begin kem_addr_o = 6'h08; kem_wdata_o = {61'd0, buf_q}; kem_wen_o = 1'b1; end
                S_IDX:   begin kem_addr_o = 6'h18; kem_wdata_o = {53'd0, off_q}; kem_wen_o = 1'b1; end
                S_PUT:   begin
                    kem_addr_o  = 6'h10;
                    kem_wdata_o = {56'd0, word_q[{lane_q, 3'b000} +: 8]};
                    kem_wen_o   = 1'b1;
                end
                default: kem_addr_o = 6'h10;
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;

    logic unused_bits;
    assign unused_bits = ^{wdata_i, kem_rdata_i[63:8]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;  buf_q <= '0;  dir_q <= 1'b0;  abort_q <= 1'b0;
            gap_q <= 1'b0;  cap_q <= 1'b0;  cap_lane_q <= '0;  lane_q <= '0;
            err_q <= '0;  be_q <= '0;  cnt_q <= '0;  len_q <= '0;  off_q <= '0;
            word_q <= '0;  rdata_q <= '0;  base_q <= '0;  cur_q <= '0;  ack_q <= 1'b0;
`ifdef MP64_KEM_DMA_IRQ_EN
            ie_q <= 1'b0;  irq_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;  buf_q <= buf_d;  dir_q <= dir_d;  abort_q <= abort_d;
            gap_q <= gap_d;  cap_q <= cap_d;  cap_lane_q <= cap_lane_d;  lane_q <= lane_d;
            err_q <= err_d;  be_q <= be_d;  cnt_q <= cnt_d;  len_q <= len_d;  off_q <= off_d;
            word_q <= word_d;  rdata_q <= rdata_d;  base_q <= base_d;  cur_q <= cur_d;  ack_q <= req_i;
`ifdef MP64_KEM_DMA_IRQ_EN
            ie_q <= ie_d;  irq_q <= irq_d;
`endif
        end
    end

endmodule

// File: tb/tb_mp64_kem_dma.sv
// tb/tb_mp64_kem_dma.sv - self-checking bench for mp64_kem_dma with memory and KEM port models

module tb_mp64_kem_dma;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, req = 1'b0, wen = 1'b0;
    logic [5:0]  addr = '0;
    logic [63:0] wdata = '0, rdata;
    logic        ack;
    logic        mem_req, mem_wen, mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata = '0;
    logic [7:0]  mem_be;
    logic        kem_req, kem_wen, kem_ack = 1'b0;
    logic [5:0]  kem_addr;
    logic [63:0] kem_wdata, kem_rdata = '0;
`ifdef MP64_KEM_DMA_IRQ_EN
    logic        irq;
`endif

    mp64_kem_dma dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .wdata_i(wdata), .wen_i(wen),
        .rdata_o(rdata), .ack_o(ack),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_wen_o(mem_wen), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
`ifdef MP64_KEM_DMA_IRQ_EN
        .irq_o(irq),
`endif
        .kem_req_o(kem_req), .kem_addr_o(kem_addr), .kem_wdata_o(kem_wdata), .kem_wen_o(kem_wen),
        .kem_rdata_i(kem_rdata), .kem_ack_i(kem_ack)
    );

    int checks = 0, errors = 0;
    int mem_reads = 0, kem_reqs = 0, kem_acks = 0, kem_stall_at = -1;
    bit mem_stall = 0, mem_delay_on = 0, kem_delay_on = 0;
    logic [69:0]  exp_kem[$];   // {addr, wdata} of expected KEM writes
    logic [103:0] exp_mem[$];   // {addr, wdata, be} of expected memory writes
    logic [7:0]   kem_src[$];   // bytes the KEM model returns on DOUT reads
    logic [7:0]   mem_b [0:16383];

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : mem_model
        logic [31:0] a; logic [63:0] wd; logic [7:0] be; logic we; int d, n; logic [103:0] e;
        forever begin
            @(posedge clk); #1;
            if (mem_req === 1'b1) begin
                a = mem_addr; wd = mem_wdata; be = mem_be; we = mem_wen;
                d = mem_delay_on ? $urandom_range(0, 5) : 0;
                n = 0;
                while ((d > 0 || mem_stall) && n < 2000) begin
                    @(posedge clk); #1; n++;
                    if (mem_req !== 1'b1) break;
                    if (d > 0) d--;
                    check("mem_hold", {a, wd, be, we}, {mem_addr, mem_wdata, mem_be, mem_wen});
                end
                if (mem_req === 1'b1) begin
                    mem_ack = 1'b1;
                    if (we) begin
                        check("mem_wr_expected", exp_mem.size() > 0, 1);
                        if (exp_mem.size() > 0) begin
                            e = exp_mem.pop_front();
                            check("mem_wr", {a, wd, be}, e);
                        end
                        for (int l = 0; l < 8; l++) if (be[l]) mem_b[a[13:0] + l] = wd[8*l +: 8];
                    end else begin
                        mem_reads++;
                        for (int l = 0; l < 8; l++) mem_rdata[8*l +: 8] = mem_b[a[13:0] + l];
                    end
                    @(posedge clk); #1;
                    mem_ack = 1'b0; mem_rdata = '0;
                end
            end
        end
    end

    initial begin : kem_model
        logic [5:0] a; logic [63:0] wd; logic we; int d, n; logic [69:0] e; logic [7:0] rv;
        forever begin
            @(posedge clk); #1;
            kem_rdata = '0;
            if (kem_req === 1'b1) begin
                kem_reqs++;
                a = kem_addr; wd = kem_wdata; we = kem_wen;
                d = kem_delay_on ? $urandom_range(0, 5) : 0;
                n = 0;
                while ((d > 0 || (kem_stall_at >= 0 && kem_acks == kem_stall_at)) && n < 2000) begin
                    @(posedge clk); #1; n++;
                    if (kem_req !== 1'b1) break;
                    if (d > 0) d--;
                    check("kem_hold", {a, wd, we}, {kem_addr, kem_wdata, kem_wen});
                end
                if (kem_req === 1'b1) begin
                    kem_ack = 1'b1;
                    kem_acks++;
                    rv = 8'h00;
                    if (we) begin
                        check("kem_wr_expected", exp_kem.size() > 0, 1);
                        if (exp_kem.size() > 0) begin
                            e = exp_kem.pop_front();
                            check("kem_wr", {a, wd}, e);
                        end
                    end else begin
                        check("kem_rd_addr", a, 6'h10);
                        check("kem_rd_expected", kem_src.size() > 0, 1);
                        if (kem_src.size() > 0) rv = kem_src.pop_front();
                    end
                    @(posedge clk); #1;
                    kem_ack = 1'b0;
                    if (!we) kem_rdata = {56'd0, rv};
                end
            end
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic csr_write(input logic [5:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        req = 1'b1; wen = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; wen = 1'b0; wdata = '0;
        check("csr_wr_ack", ack, 1'b1);
    endtask

    task automatic csr_read(input logic [5:0] a, output logic [63:0] d);
        @(posedge clk); #1;
        req = 1'b1; wen = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        check("csr_rd_ack", ack, 1'b1);
        d = rdata;
    endtask

    task automatic wait_done(output logic [63:0] st);
        st = '0;
        for (int n = 0; n < 30000; n++) begin
            csr_read(6'h00, st);
            if (st[1:0] != 2'd1) break;
        end
    endtask

    task automatic push_kem(input logic [5:0] a, input logic [63:0] d);
        exp_kem.push_back({a, d});
    endtask

    initial begin : main
        logic [63:0] st, w;
        int r0, m0;
        for (int i = 0; i < 16384; i++) mem_b[i] = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_outs", {mem_req, mem_addr, mem_wdata, mem_be, mem_wen}, '0);
        check("reset_kem_outs", {kem_req, kem_addr, kem_wdata, kem_wen, ack, rdata}, '0);
        rst = 1'b0;
        csr_read(6'h00, st);
        check("reset_status", st, 64'd0);
        csr_read(6'h08, st);
        check("reset_mem_addr", st, 64'd0);

        // 1: 64 bytes mem->kem, BUF 0
        for (int i = 0; i < 64; i++) mem_b[16'h1000 + i] = 8'(i + 1);
        push_kem(6'h08, 64'd0);
        push_kem(6'h18, 64'd0);
        for (int i = 0; i < 64; i++) push_kem(6'h10, 64'(i + 1));
        mem_reads = 0;
        csr_write(6'h08, 64'h1005);
        csr_read(6'h08, st);
        check("t1_addr_aligned", st, 64'h1000);
        csr_write(6'h10, 64'd64);
        csr_write(6'h18, 64'd0);
        csr_write(6'h00, 64'h01);
        wait_done(st);
        check("t1_status", st[31:0], 32'h0040_0002);
        check("t1_mem_reads", mem_reads, 8);
        check("t1_kem_left", exp_kem.size(), 0);

        // 2: 12-byte SS unload, BUF 4, OFFSET 20
        for (int i = 0; i < 12; i++) kem_src.push_back(8'hA0 + 8'(i));
        push_kem(6'h08, 64'd4);
        push_kem(6'h18, 64'd20);
        exp_mem.push_back({32'h2000, 64'hA7A6_A5A4_A3A2_A1A0, 8'hFF});
        exp_mem.push_back({32'h2008, 64'h0000_0000_ABAA_A9A8, 8'h0F});
        csr_write(6'h08, 64'h2000);
        csr_write(6'h10, 64'd12);
        csr_write(6'h18, 64'd20);
        csr_write(6'h00, 64'h13);
        wait_done(st);
        check("t2_status", st[31:0], 32'h000C_0002);
        check("t2_mem_left", exp_mem.size(), 0);
        check("t2_kem_left", exp_kem.size(), 0);

        // 3: validation errors, no bus traffic
        r0 = kem_reqs; m0 = mem_reads;
        csr_write(6'h10, 64'd8);
        csr_write(6'h18, 64'd0);
        csr_write(6'h00, 64'h15);
        wait_done(st);
        check("t3_bad_buf", st[31:0], 32'h0000_0103);
        csr_write(6'h10, 64'd4);
        csr_write(6'h18, 64'd30);
        csr_write(6'h00, 64'h11);
        wait_done(st);
        check("t3_overrun", st[31:0], 32'h0000_0203);
        csr_write(6'h10, 64'd0);
        csr_write(6'h18, 64'd0);
        csr_write(6'h00, 64'h01);
        wait_done(st);
        check("t3_len_zero", st[31:0], 32'h0000_0303);
        check("t3_no_kem_req", kem_reqs, r0);
        check("t3_no_mem_req", mem_reads, m0);

        // 4: 1632-byte SK unload with random ack delays; START/LEN writes while busy ignored
        mem_delay_on = 1; kem_delay_on = 1;
        push_kem(6'h08, 64'd2);
        push_kem(6'h18, 64'd0);
        for (int wi = 0; wi < 204; wi++) begin
            for (int l = 0; l < 8; l++) begin
                w[8*l +: 8] = 8'($urandom_range(0, 255));
                kem_src.push_back(w[8*l +: 8]);
            end
            exp_mem.push_back({32'h3000 + 32'(8 * wi), w, 8'hFF});
        end
        csr_write(6'h08, 64'h3000);
        csr_write(6'h10, 64'd1632);
        csr_write(6'h00, 64'h0B);
        csr_write(6'h10, 64'd5);
        csr_write(6'h00, 64'h05);
        wait_done(st);
        check("t4_status", st[31:0], 32'h0660_0002);
        csr_read(6'h10, st);
        check("t4_len_kept", st, 64'd1632);
        check("t4_mem_left", exp_mem.size(), 0);
        check("t4_src_left", kem_src.size(), 0);
        mem_delay_on = 0; kem_delay_on = 0;

        // 5a: ABORT with the 11th DIN write outstanding
        push_kem(6'h08, 64'd0);
        push_kem(6'h18, 64'd0);
        for (int i = 0; i < 11; i++) push_kem(6'h10, 64'(i + 1));
        kem_acks = 0;
        kem_stall_at = 12;
        csr_write(6'h08, 64'h1000);
        csr_write(6'h10, 64'd64);
        csr_write(6'h00, 64'h01);
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            if (kem_acks == 12 && kem_req === 1'b1) break;
        end
        check("t5_stalled_put", kem_req, 1'b1);
        csr_write(6'h00, 64'h20);
        kem_stall_at = -1;
        wait_done(st);
        check("t5_abort_status", st[31:0], 32'h000A_0000);
        check("t5_kem_left", exp_kem.size(), 0);

        // 5b: reset while a FETCH is waiting
        push_kem(6'h08, 64'd0);
        push_kem(6'h18, 64'd0);
        mem_stall = 1;
        csr_write(6'h00, 64'h01);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (mem_req === 1'b1) break;
        end
        check("t5_fetch_seen", mem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_mem_outs", {mem_req, mem_addr, mem_wdata, mem_be, mem_wen}, '0);
        check("t5_rst_kem_outs", {kem_req, kem_addr, kem_wdata, kem_wen, ack, rdata}, '0);
        rst = 1'b0;
        mem_stall = 0;
        csr_read(6'h00, st);
        check("t5_status_after_rst", st, 64'd0);
        check("t5_kem_left2", exp_kem.size(), 0);

`ifdef MP64_KEM_DMA_IRQ_EN
        // 6: interrupt on DONE, cleared by bit7
        push_kem(6'h08, 64'd0);
        push_kem(6'h18, 64'd0);
        for (int i = 0; i < 8; i++) push_kem(6'h10, 64'(i + 1));
        csr_write(6'h08, 64'h1000);
        csr_write(6'h10, 64'd8);
        check("t6_irq_idle", irq, 1'b0);
        csr_write(6'h00, 64'h41);
        wait_done(st);
        check("t6_status", st[31:0], 32'h0008_0002);
        check("t6_irq_set", irq, 1'b1);
        csr_write(6'h00, 64'h80);
        check("t6_irq_clr", irq, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp64_kem_dma.md
Name: mp64_kem_dma

Overview:
- Bus-mastering byte mover between system memory and the mp64_kem accelerator's byte-serial buffer port.
- The CPU programs a source/destination address, length, KEM buffer ID and buffer offset, then starts a transfer.
- The block then drives the KEM MMIO port itself: BUF_SEL, then IDX_SET, then repeated DIN or DOUT accesses.
- It sits directly upstream (seed/PK/CT loading) and downstream (PK/SK/CT/SS unloading) of the KEM; the CPU never touches DIN/DOUT during a transfer.

Parameters:
- MAX_LEN, 2048, largest accepted transfer length in bytes; LEN field is 12 bits.
- MEM_AW, 32, memory byte-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  1  CSR slave request
- addr  in  6  CSR byte offset
- wdata  in  64  CSR write data
- wen  in  1  CSR write enable
- rdata  out  64  CSR read data, registered
- ack  out  1  CSR acknowledge
- mem_req  out  1  memory master request
- mem_addr  out  MEM_AW  memory address, 8-byte aligned
- mem_wdata  out  64  memory write data
- mem_be  out  8  memory byte enables
- mem_wen  out  1  memory write
- mem_rdata  in  64  memory read data
- mem_ack  in  1  memory acknowledge
- kem_req  out  1  KEM port request
- kem_addr  out  6  KEM register offset
- kem_wdata  out  64  KEM write data
- kem_wen  out  1  KEM write
- kem_rdata  in  64  KEM read data
- kem_ack  in  1  KEM acknowledge

Behaviour:

CSR map:
- 0x00 CTRL/STATUS.
  - Write: bit0 START; bit1 DIR (0 = mem→kem, 1 = kem→mem); bits[4:2] BUF; bit5 ABORT.
  - Read: [1:0] state (0 idle, 1 busy, 2 done, 3 error); [15:8] error code (1 bad BUF, 2 overrun, 3 LEN=0); [31:16] bytes moved.
- 0x08 MEM_ADDR. Bits[2:0] are ignored and forced to 0.
- 0x10 LEN, 12 bits.
- 0x18 OFFSET, 11 bits.
- ack is asserted one cycle after every req. rdata is valid in that same ack cycle.

Reset:
- All outputs are 0.
- Registers are 0.
- FSM is IDLE.
- Status reads 0.

Start and validation:
- START is accepted only in IDLE, DONE or ERR. START while busy is ignored.
- Checks are done in a 1-cycle CHECK state:
  - BUF > 4 gives error 1.
  - OFFSET + LEN > size(BUF) gives error 2. Sizes: 64, 800, 1632, 768, 32.
  - LEN = 0 gives error 3.
- A failed check goes to ERR. No bus traffic occurs.

FSM: IDLE → CHECK → SEL → IDX → (mem→kem: FETCH → PUT) or (kem→mem: GET → STORE) → DONE or ERR.
- SEL: KEM write of {61'd0, BUF} to 0x08.
- IDX: KEM write of OFFSET to 0x18.

Master handshake (both ports):
- req, addr, wdata and wen are held stable until the ack is sampled high.
- req drops for at least one cycle between transactions.
- mem_rdata is captured in the mem_ack cycle.
- kem_rdata is captured in the cycle after kem_ack.

mem→kem path:
- FETCH reads the 64-bit word at the current address.
- PUT writes {56'd0, byte} to KEM 0x10, little-endian: lane 0 first.
- After lane 7, or after the last byte, the address advances by 8. The next FETCH happens only if bytes remain.

kem→mem path:
- GET reads KEM 0x10 and packs the byte into the lane counter position.
- STORE writes when lane 7 is filled or on the last byte.
- mem_be has ones for the filled lanes only. Unfilled lanes of mem_wdata are 0.

Completion and abort:
- The byte counter increments per completed KEM data access.
- When count = LEN the FSM goes to DONE.
- ABORT while busy finishes the outstanding handshake, then goes to IDLE. The count is retained.
- rst mid-transfer returns the FSM to IDLE immediately. Master req is deasserted the same cycle.

Simultaneous events:
- A CSR write to MEM_ADDR, LEN or OFFSET while busy is ignored.
- Status reads are always allowed.

Optional Feature:
- Macro: MP64_KEM_DMA_IRQ_EN.
- With it defined:
  - Adds output irq (1 bit, reset 0).
  - CTRL bit6 is IE.
  - irq is set on entry to DONE or ERR when IE = 1.
  - irq is cleared by writing CTRL with bit7 = 1, or by a new START.
- Without it: no irq port; bits 6 and 7 are ignored and read 0.

Test Plan:
1. Memory holds 64 bytes 0x01..0x40 at 0x1000. Program BUF=0, OFFSET=0, LEN=64, DIR=0, START. The bench must see KEM writes 0x08←0 then 0x18←0, then 64 DIN writes 0x01..0x40 in order, exactly 8 memory reads, and STATUS = 2 with count = 64.
2. KEM SS model returns bytes 0xA0..0xAB. Program BUF=4, OFFSET=20, LEN=12, DIR=1, address 0x2000. The bench must see IDX write 20, a word at 0x2000 with be = 0xFF, a word at 0x2008 with be = 0x0F and upper lanes 0, and STATUS = 2.
3. BUF=5 → STATUS = 3, error code 1, no kem_req. BUF=4, OFFSET=30, LEN=4 → error code 2. LEN=0 → error code 3.
4. Random 0–5 cycle ack delays on both ports with a 1632-byte SK unload (BUF=2) → data identical to the model, and req/addr/wdata stable while waiting.
5. ABORT after 10 bytes → FSM idle within one handshake and count = 10. rst asserted mid-FETCH → all outputs 0 next cycle.
6. With MP64_KEM_DMA_IRQ_EN: IE=1, LEN=8 → irq rises on DONE and clears on write 0x80. START while busy is ignored and no counters change.
